memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_pkg.sv | 40 ++++
 rtl/load_store_align.sv | 53 +++++
 rtl/memory_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: mem_op encodings, FSM states and
// small op-classification helpers used by the stage and its lane aligner.
package memory_stage_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Halfword ops need an even address, word ops a multiple of four.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] offset);
    case (op)
      OP_LH, OP_LHU, OP_SH: return offset[0];
      OP_LW, OP_SW:         return |offset;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables, store replication and load
// extraction with sign/zero extension for a big-endian 32-bit bus.
module load_store_align
  import memory_stage_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    be_o        = '0;
    wdata_o     = '0;
    load_data_o = '0;

    case (offset_i)
      2'd0:    lane_b = rdata_i[31:24];
      2'd1:    lane_b = rdata_i[23:16];
      2'd2:    lane_b = rdata_i[15:8];
      default: lane_b = rdata_i[7:0];
    endcase
    // Offset bit 0 is ignored for halves, so offsets 1/3 fold onto 0/2.
    lane_h = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    case (op_i)
      OP_LB, OP_LBU, OP_SB: be_o = 4'b1000 >> offset_i;
      OP_LH, OP_LHU, OP_SH: be_o = offset_i[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_SW:         be_o = 4'b1111;
      default:              be_o = 4'b0000;
    endcase

    case (op_i)
      OP_LB:   load_data_o = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_data_o = {24'd0, lane_b};
      OP_LH:   load_data_o = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_data_o = {16'd0, lane_h};
      OP_LW:   load_data_o = rdata_i;
      OP_SB:   wdata_o     = {4{store_data_i[7:0]}};
      OP_SH:   wdata_o     = {2{store_data_i[15:0]}};
      OP_SW:   wdata_o     = store_data_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: IDLE/REQ/DONE handshake between Execute, data memory
// and Writeback. Define MEM_ALIGN_CHECK_EN to fault misaligned half/word ops.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] rt_data,
  input  logic [3:0]  mem_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        misalign
);

  state_e      state_q, state_d;
  logic [3:0]  op_q;
  logic [31:0] addr_q, rt_q;
  logic [31:0] out_data_q, out_data_d;
  logic        accept, misalign_now;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;

  assign accept = in_valid & in_ready;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign misalign_now = is_misaligned(mem_op, alu_result[1:0]);

  always_comb begin
    misalign_d = misalign_q;
    if (accept)                            misalign_d = misalign_now;
    else if (state_q == ST_DONE && out_ready) misalign_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) misalign_q <= 1'b0;
    else          misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign misalign_now = 1'b0;
  assign misalign     = 1'b0;
`endif

  load_store_align u_align (
    .op_i         (op_q),
    .offset_i     (addr_q[1:0]),
    .store_data_i (rt_q),
    .rdata_i      (mem_rdata),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .load_data_o  (lane_load)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (is_mem_op(mem_op) && !misalign_now) ? ST_REQ : ST_DONE;
      ST_REQ:  if (mem_ack) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    mem_req   = (state_q == ST_REQ);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (state_q == ST_REQ) begin
      mem_we    = is_store_op(op_q);
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_be    = lane_be;
      mem_wdata = lane_wdata;
    end
  end

  // Passthrough and alignment faults resolve at accept; memory ops on ack.
  always_comb begin
    out_data_d = out_data_q;
    if (accept && (!is_mem_op(mem_op) || misalign_now))
      out_data_d = alu_result;
    else if (state_q == ST_REQ && mem_ack)
      out_data_d = is_store_op(op_q) ? '0 : lane_load;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= '0;
      addr_q     <= '0;
      rt_q       <= '0;
      out_data_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= mem_op;
        addr_q <= alu_result;
        rt_q   <= rt_data;
      end
      out_data_q <= out_data_d;
    end
  end

  assign out_data = out_data_q;

endmodule
